spi_slave: RTL

Synchronous SPI slave sitting on the far side of the link from `spi_master`: it consumes `cs_o`/`spiClk_o`/`mosi_o` and drives the master's `miso_i`. All SPI inputs are oversampled in the local `clk_i` domain; no logic is clocked by the SPI clock. Each completed 8-bit frame is presented as a parallel byte with a one-cycle valid strobe, and the next transmit byte is captured from a parallel input with a one-cycle acknowledge.

---
 rtl/spi_slave.sv | 139 +++++++++++++
 1 files changed

// File: rtl/spi_slave.sv
// SPI slave with every SPI pin oversampled in the clk_i domain; nothing runs on the SPI clock.
// Frames are MSB first and are exchanged as parallel words with one-cycle strobes.
module spi_slave #(
  parameter bit clkPolarity = 1'b0,
  parameter bit clkPhase    = 1'b0,
  parameter int dataWidth   = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cs_i,
  input  logic                 spiClk_i,
  input  logic                 mosi_i,
  output logic                 miso_o,
  input  logic [dataWidth-1:0] tx_data_i,
  output logic                 tx_ack_o,
  output logic [dataWidth-1:0] rx_data_o,
  output logic                 rx_valid_o,
  output logic                 frame_err_o
);

  localparam int              CW       = $clog2(dataWidth + 1);
  localparam logic [CW-1:0]   LAST_BIT = CW'(dataWidth - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  state_t               state, state_next;
  logic [2:0]           cs_pipe, sclk_pipe;
  logic [1:0]           mosi_pipe;
  logic [dataWidth-1:0] tx_sr;
  logic [dataWidth-2:0] rx_sr;
  logic [dataWidth-1:0] rx_next;
  logic [CW-1:0]        bit_cnt;
  logic                 skip_shift;
  logic                 lead_edge, trail_edge, sample_edge, shift_edge;
  logic                 cs_fall, cs_high;
  logic                 do_load, do_sample, do_shift, do_abort, frame_done;

  // NOTE: synchronizer stages are left unreset: they flush on their own, and keeping the
  // CS history across a reset means a reset with CS held low cannot look like a new CS fall.
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments so each stage takes the previous stage's old value.
    cs_pipe   <= {cs_pipe[1:0], cs_i};
    sclk_pipe <= {sclk_pipe[1:0], spiClk_i};
    mosi_pipe <= {mosi_pipe[0], mosi_i};
  end

  assign lead_edge   = (sclk_pipe[1] != clkPolarity) && (sclk_pipe[2] == clkPolarity);
  assign trail_edge  = (sclk_pipe[1] == clkPolarity) && (sclk_pipe[2] != clkPolarity);
  assign sample_edge = clkPhase ? trail_edge : lead_edge;
  assign shift_edge  = clkPhase ? lead_edge  : trail_edge;
  assign cs_fall     = !cs_pipe[1] && cs_pipe[2];
  assign cs_high     = cs_pipe[1];
  assign rx_next     = {rx_sr, mosi_pipe[1]};

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
    state_next = state;
    do_load    = 1'b0;
    do_sample  = 1'b0;
    do_shift   = 1'b0;
    do_abort   = 1'b0;
    frame_done = 1'b0;
    unique case (state)
      IDLE: if (cs_fall) state_next = LOAD;
      LOAD: begin
        do_load    = 1'b1;
        state_next = SHIFT;
      end
      SHIFT: begin
        // A CS release takes priority over any clock edge seen in the same cycle.
        if (cs_high) begin
          do_abort   = (bit_cnt != '0);
          state_next = IDLE;
        end else if (sample_edge) begin
          do_sample  = 1'b1;
          frame_done = (bit_cnt == LAST_BIT);
        end else if (shift_edge) begin
          do_shift = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // tx_data_i is captured in exactly the cycle this strobe is high.
  assign tx_ack_o = !rst_i && (do_load || frame_done);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_sr       <= '0;
      rx_sr       <= '0;
      bit_cnt     <= '0;
      skip_shift  <= 1'b0;
      miso_o      <= 1'b0;
      rx_data_o   <= '0;
      rx_valid_o  <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      rx_valid_o  <= 1'b0;
      frame_err_o <= do_abort;
      if (state == IDLE) begin
        miso_o  <= 1'b0;
        bit_cnt <= '0;
      end else if (do_load) begin
        tx_sr      <= tx_data_i;
        miso_o     <= tx_data_i[dataWidth-1];
        bit_cnt    <= '0;
        skip_shift <= clkPhase;
      end else if (do_sample) begin
        rx_sr <= rx_next[dataWidth-2:0];
        if (frame_done) begin
          rx_data_o  <= rx_next;
          rx_valid_o <= 1'b1;
          bit_cnt    <= '0;
          tx_sr      <= tx_data_i;
          skip_shift <= 1'b1;
          if (!clkPhase) miso_o <= tx_data_i[dataWidth-1];
        end else begin
          bit_cnt <= bit_cnt + CW'(1);
        end
      end else if (do_shift) begin
        // The first shift edge after a (re)load only presents the MSB already in tx_sr.
        if (skip_shift) begin
          skip_shift <= 1'b0;
          miso_o     <= tx_sr[dataWidth-1];
        end else begin
          tx_sr  <= tx_sr << 1;
          miso_o <= tx_sr[dataWidth-2];
        end
      end
    end
  end

endmodule
